// File: rtl/bic_frame_counter.sv
// Receive-path bit-index counter: counts bit-sample strobes, deserialises the line LSB-first and flags each complete character.
// Define BIC_PARITY_EN to add a parity slot after the data bits, the PARITY_ODD parameter and the parityErr output.
module bic_frame_counter #(
    parameter int unsigned  DATA_BITS  = 8,
    parameter int unsigned  STOP_BITS  = 1,
`ifdef BIC_PARITY_EN
    parameter bit           PARITY_ODD = 1'b0,
    localparam int unsigned PAR_BITS   = 1,
`else
    localparam int unsigned PAR_BITS   = 0,
`endif
    localparam int unsigned FRAME_LEN  = 1 + DATA_BITS + PAR_BITS + STOP_BITS,
    localparam int unsigned CW         = $clog2(FRAME_LEN + 1)
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 enable,
    input  logic                 bitStrobe,
    input  logic                 rxBit,
    output logic                 charRec,
    output logic [DATA_BITS-1:0] dataOut,
    output logic                 frameErr,
`ifdef BIC_PARITY_EN
    output logic                 parityErr,
`endif
    output logic                 busy,
    output logic [CW-1:0]        bitIndex
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } state_t;

    state_t               state;
    logic [CW-1:0]        idx_nxt;
    logic                 last_bit;
    logic [DATA_BITS-1:0] shift_q;
    logic [DATA_BITS-1:0] shift_nxt;
    logic                 stop_err_q;
    logic                 stop_err_nxt;
    logic                 done_c;
    logic                 frame_err_c;
`ifdef BIC_PARITY_EN
    logic                 par_q;
    logic                 par_nxt;
`endif

    // Frame phase is a pure decode of the bit position.
    always_comb begin
        if (bitIndex == '0) begin
            state = ST_IDLE;
        end else if (bitIndex <= CW'(DATA_BITS)) begin
            state = ST_DATA;
        end else if (bitIndex <= CW'(DATA_BITS + PAR_BITS)) begin
            state = ST_PARITY;
        end else begin
            state = ST_STOP;
        end
    end

    assign last_bit = (bitIndex == CW'(FRAME_LEN - 1));
    assign busy     = (bitIndex != '0);

    // State register: the bit position itself.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            bitIndex <= '0;
        end else begin
            bitIndex <= idx_nxt;
        end
    end

    // Next bit position; enable low aborts the frame before any strobe is seen.
    always_comb begin
        idx_nxt = bitIndex;
        if (!enable) begin
            idx_nxt = '0;
        end else if (bitStrobe) begin
            if (state == ST_IDLE) begin
                idx_nxt = rxBit ? '0 : CW'(1);
            end else if (last_bit) begin
                idx_nxt = '0;
            end else begin
                idx_nxt = bitIndex + CW'(1);
            end
        end
    end

    // Datapath updates and completion detect for the current strobe.
    always_comb begin
        shift_nxt    = shift_q;
        stop_err_nxt = stop_err_q;
        done_c       = 1'b0;
        frame_err_c  = stop_err_q | ~rxBit;
`ifdef BIC_PARITY_EN
        par_nxt      = par_q;
`endif
        if (!enable) begin
            shift_nxt    = '0;
            stop_err_nxt = 1'b0;
`ifdef BIC_PARITY_EN
            par_nxt      = 1'b0;
`endif
        end else if (bitStrobe) begin
            unique case (state)
                ST_DATA: begin
                    shift_nxt = {rxBit, shift_q[DATA_BITS-1:1]};
`ifdef BIC_PARITY_EN
                    par_nxt   = par_q ^ rxBit;
`endif
                end
                ST_PARITY: begin
`ifdef BIC_PARITY_EN
                    par_nxt = par_q ^ rxBit;
`endif
                end
                ST_STOP: begin
                    if (last_bit) begin
                        done_c       = 1'b1;
                        shift_nxt    = '0;
                        stop_err_nxt = 1'b0;
`ifdef BIC_PARITY_EN
                        par_nxt      = 1'b0;
`endif
                    end else begin
                        stop_err_nxt = stop_err_q | ~rxBit;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Internal frame state plus the character outputs, which hold between completions.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            shift_q    <= '0;
            stop_err_q <= 1'b0;
            charRec    <= 1'b0;
            dataOut    <= '0;
            frameErr   <= 1'b0;
`ifdef BIC_PARITY_EN
            par_q      <= 1'b0;
            parityErr  <= 1'b0;
`endif
        end else begin
            shift_q    <= shift_nxt;
            stop_err_q <= stop_err_nxt;
            charRec    <= done_c;
`ifdef BIC_PARITY_EN
            par_q      <= par_nxt;
`endif
            if (done_c) begin
                dataOut   <= shift_q;
                frameErr  <= frame_err_c;
`ifdef BIC_PARITY_EN
                parityErr <= par_q ^ PARITY_ODD;
`endif
            end
        end
    end

endmodule

// File: tb/tb_bic_frame_counter.sv
// Self-checking bench for bic_frame_counter: default 8N1 instance plus a 7-data/2-stop instance.
`timescale 1ns/1ps
module tb_bic_frame_counter;

`ifdef BIC_PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif
    localparam int FL0 = 1 + 8 + P + 1;
    localparam int FL7 = 1 + 7 + P + 2;

    typedef struct {
        logic [8:0] data;
        logic       ferr;
        logic       perr;
    } exp_t;

    typedef struct {
        logic [7:0] data;
        logic       start;
        logic       stop;
        int         gap;
        logic [7:0] exp_data;
        logic       exp_ferr;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset_n, enable;
    logic       bitStrobe, rxBit, strobe7, rx7;
    logic       charRec, frameErr, busy;
    logic [7:0] dataOut;
    logic [3:0] bitIndex;
    logic       charRec7, frameErr7, busy7;
    logic [6:0] dataOut7;
    logic [3:0] bitIndex7;
`ifdef BIC_PARITY_EN
    logic       parityErr, parityErr7;
`endif

    int   n_checks = 0;
    int   n_err    = 0;
    exp_t q0[$];
    exp_t q7[$];
    logic fbits[$];
    bit   prev0, prev7;
    vec_t vt[6];

    always #5 clk = ~clk;

    bic_frame_counter u_dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .enable    (enable),
        .bitStrobe (bitStrobe),
        .rxBit     (rxBit),
        .charRec   (charRec),
        .dataOut   (dataOut),
        .frameErr  (frameErr),
`ifdef BIC_PARITY_EN
        .parityErr (parityErr),
`endif
        .busy      (busy),
        .bitIndex  (bitIndex)
    );

    bic_frame_counter #(.DATA_BITS(7), .STOP_BITS(2)) u_dut7 (
        .clk       (clk),
        .reset_n   (reset_n),
        .enable    (enable),
        .bitStrobe (strobe7),
        .rxBit     (rx7),
        .charRec   (charRec7),
        .dataOut   (dataOut7),
        .frameErr  (frameErr7),
`ifdef BIC_PARITY_EN
        .parityErr (parityErr7),
`endif
        .busy      (busy7),
        .bitIndex  (bitIndex7)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        n_checks++;
        if (act !== want) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, want, $time);
        end
    endtask

    function automatic logic [31:0] idx_of(input bit sel);
        return sel ? 32'(bitIndex7) : 32'(bitIndex);
    endfunction

    function automatic logic [31:0] busy_of(input bit sel);
        return sel ? 32'(busy7) : 32'(busy);
    endfunction

    function automatic logic [31:0] rec_of(input bit sel);
        return sel ? 32'(charRec7) : 32'(charRec);
    endfunction

    // Advance one clock, then score any charRec pulse against the expected queue.
    task automatic step();
        exp_t e;
        @(posedge clk);
        #1;
        if (prev0) check("charRec pulse width", 32'(charRec), 32'd0);
        if (charRec === 1'b1) begin
            if (q0.size() == 0) begin
                n_checks++;
                n_err++;
                $display("FAIL charRec unexpected: got 1, expected 0 at %0t", $time);
            end else begin
                e = q0.pop_front();
                check("dataOut", 32'(dataOut), 32'(e.data));
                check("frameErr", 32'(frameErr), 32'(e.ferr));
`ifdef BIC_PARITY_EN
                check("parityErr", 32'(parityErr), 32'(e.perr));
`endif
            end
        end
        prev0 = (charRec === 1'b1);
        if (prev7) check("charRec7 pulse width", 32'(charRec7), 32'd0);
        if (charRec7 === 1'b1) begin
            if (q7.size() == 0) begin
                n_checks++;
                n_err++;
                $display("FAIL charRec7 unexpected: got 1, expected 0 at %0t", $time);
            end else begin
                e = q7.pop_front();
                check("dataOut7", 32'(dataOut7), 32'(e.data));
                check("frameErr7", 32'(frameErr7), 32'(e.ferr));
`ifdef BIC_PARITY_EN
                check("parityErr7", 32'(parityErr7), 32'(e.perr));
`endif
            end
        end
        prev7 = (charRec7 === 1'b1);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic strobe(input bit sel, input logic b);
        if (sel) begin
            strobe7 = 1'b1;
            rx7     = b;
        end else begin
            bitStrobe = 1'b1;
            rxBit     = b;
        end
        step();
        bitStrobe = 1'b0;
        strobe7   = 1'b0;
        rxBit     = 1'($urandom);
        rx7       = 1'($urandom);
    endtask

    function automatic exp_t make_exp(input bit sel, input logic [8:0] data, input logic pbit,
                                      input logic [1:0] stops);
        exp_t e;
        if (sel) begin
            e.data = {2'b00, data[6:0]};
            e.ferr = ~(stops[0] & stops[1]);
        end else begin
            e.data = {1'b0, data[7:0]};
            e.ferr = ~stops[0];
        end
        e.perr = (^e.data) ^ pbit;
        return e;
    endfunction

    // Send the first nstr bits of a frame, checking the bit position after every strobe.
    task automatic frame(input bit sel, input logic [8:0] data, input logic pbit,
                         input logic [1:0] stops, input int nstr, input int gap);
        int   fl;
        exp_t e;
        fl = sel ? FL7 : FL0;
        fbits.delete();
        fbits.push_back(1'b0);
        for (int i = 0; i < (sel ? 7 : 8); i++) fbits.push_back(data[i]);
        if (P == 1) fbits.push_back(pbit);
        for (int i = 0; i < (sel ? 2 : 1); i++) fbits.push_back(stops[i]);
        e = make_exp(sel, data, pbit, stops);
        for (int k = 0; k < nstr; k++) begin
            if (k == fl - 1) begin
                if (sel) q7.push_back(e);
                else     q0.push_back(e);
            end
            strobe(sel, fbits[k]);
            if (k == fl - 1) begin
                check("bitIndex wrap", idx_of(sel), 32'd0);
                check("charRec latency", rec_of(sel), 32'd1);
            end else begin
                check("bitIndex step", idx_of(sel), 32'(k + 1));
                check("busy in frame", busy_of(sel), 32'd1);
                for (int g = 0; g < gap; g++) begin
                    step();
                    check("bitIndex hold", idx_of(sel), 32'(k + 1));
                end
            end
        end
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout, expected bench to finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n   = 1'b0;
        enable    = 1'b0;
        bitStrobe = 1'b0;
        rxBit     = 1'b0;
        strobe7   = 1'b0;
        rx7       = 1'b0;
        prev0     = 1'b0;
        prev7     = 1'b0;
        idle(3);
        check("reset charRec", 32'(charRec), 32'd0);
        check("reset dataOut", 32'(dataOut), 32'd0);
        check("reset frameErr", 32'(frameErr), 32'd0);
        check("reset busy", 32'(busy), 32'd0);
        check("reset bitIndex", 32'(bitIndex), 32'd0);
        check("reset dataOut7", 32'(dataOut7), 32'd0);
`ifdef BIC_PARITY_EN
        check("reset parityErr", 32'(parityErr), 32'd0);
`endif
        reset_n = 1'b1;
        idle(1);
        enable = 1'b1;
        idle(1);

        // data, start, stop, gap, held dataOut, held frameErr
        vt[0] = '{8'hA5, 1'b0, 1'b1, 1, 8'hA5, 1'b0};
        vt[1] = '{8'h3C, 1'b0, 1'b0, 2, 8'h3C, 1'b1};
        vt[2] = '{8'h81, 1'b0, 1'b1, 0, 8'h81, 1'b0};
        vt[3] = '{8'hFF, 1'b1, 1'b1, 0, 8'h81, 1'b0};
        vt[4] = '{8'h00, 1'b0, 1'b1, 3, 8'h00, 1'b0};
        vt[5] = '{8'h5A, 1'b0, 1'b0, 0, 8'h5A, 1'b1};
        foreach (vt[i]) begin
            if (vt[i].start) begin
                strobe(1'b0, 1'b1);
                check("false start bitIndex", 32'(bitIndex), 32'd0);
                check("false start busy", 32'(busy), 32'd0);
                idle(2);
                check("false start charRec", 32'(charRec), 32'd0);
            end else begin
                frame(1'b0, {1'b0, vt[i].data}, ^vt[i].data, {1'b1, vt[i].stop}, FL0, vt[i].gap);
            end
            check("vec dataOut", 32'(dataOut), 32'(vt[i].exp_data));
            check("vec frameErr", 32'(frameErr), 32'(vt[i].exp_ferr));
            idle(1);
        end

        // Abort at bitIndex 5: outputs keep the last character.
        frame(1'b0, 9'h0C3, ^8'hC3, 2'b11, 5, 0);
        enable = 1'b0;
        step();
        check("abort bitIndex", 32'(bitIndex), 32'd0);
        check("abort busy", 32'(busy), 32'd0);
        check("abort charRec", 32'(charRec), 32'd0);
        check("abort dataOut held", 32'(dataOut), 32'h5A);
        check("abort frameErr held", 32'(frameErr), 32'd1);
        enable = 1'b1;
        step();

        // Final strobe coincides with enable low: enable wins.
        frame(1'b0, 9'h099, ^8'h99, 2'b11, FL0 - 1, 0);
        bitStrobe = 1'b1;
        rxBit     = 1'b1;
        enable    = 1'b0;
        step();
        bitStrobe = 1'b0;
        check("late abort bitIndex", 32'(bitIndex), 32'd0);
        check("late abort charRec", 32'(charRec), 32'd0);
        check("late abort dataOut", 32'(dataOut), 32'h5A);
        enable = 1'b1;
        step();
        frame(1'b0, 9'h0E7, ^8'hE7, 2'b11, FL0, 1);
        check("good after abort frameErr", 32'(frameErr), 32'd0);
        idle(1);

        // 7 data / 2 stop, back-to-back strobes; second start lands on the charRec cycle.
        frame(1'b1, 9'h055, ^7'h55, 2'b11, FL7, 0);
        check("charRec7 at next start", 32'(charRec7), 32'd1);
        frame(1'b1, 9'h02A, ^7'h2A, 2'b11, FL7, 0);
        check("b2b dataOut7", 32'(dataOut7), 32'h2A);
        idle(1);

        // Stop-error from an aborted frame must not leak into the next one.
        frame(1'b1, 9'h011, ^7'h11, 2'b10, FL7 - 1, 1);
        enable = 1'b0;
        step();
        enable = 1'b1;
        step();
        frame(1'b1, 9'h022, ^7'h22, 2'b11, FL7, 0);
        check("stop flag cleared", 32'(frameErr7), 32'd0);
        frame(1'b1, 9'h07F, ^7'h7F, 2'b01, FL7, 2);
        check("second stop bad", 32'(frameErr7), 32'd1);
        idle(1);

        // Reset mid-frame.
        frame(1'b0, 9'h0B6, ^8'hB6, 2'b11, 4, 0);
        reset_n = 1'b0;
        step();
        check("midreset bitIndex", 32'(bitIndex), 32'd0);
        check("midreset dataOut", 32'(dataOut), 32'd0);
        check("midreset frameErr", 32'(frameErr), 32'd0);
        check("midreset busy", 32'(busy), 32'd0);
        check("midreset dataOut7", 32'(dataOut7), 32'd0);
        check("midreset frameErr7", 32'(frameErr7), 32'd0);
        reset_n = 1'b1;
        step();
        frame(1'b0, 9'h0A5, ^8'hA5, 2'b11, FL0, 0);
        check("post reset dataOut", 32'(dataOut), 32'hA5);

`ifdef BIC_PARITY_EN
        idle(1);
        frame(1'b0, 9'h007, 1'b0, 2'b11, FL0, 0);
        check("parity bad", 32'(parityErr), 32'd1);
        idle(1);
        frame(1'b0, 9'h007, 1'b1, 2'b11, FL0, 0);
        check("parity good", 32'(parityErr), 32'd0);
`endif

        idle(3);
        check("scoreboard drained", 32'(q0.size()), 32'd0);
        check("scoreboard7 drained", 32'(q7.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/bic_frame_counter.md
# bic_frame_counter

Parametrised successor to the bit-index counter in the serial receive path. Counts bit-sample strobes from the bit-sample clock generator, deserialises the sampled line LSB-first, and flags a complete character with a one-cycle registered pulse plus framing status. Fully synchronous to the system clock instead of being clocked by the BSC state line. Sits between the BSC and the receive holding register.

## Interface
- DATA_BITS, 8, data bits per character (5..9)
- STOP_BITS, 1, stop bits per character (1 or 2)
- clk  input  1  system clock; all logic on rising edge
- reset_n  input  1  synchronous, active-low reset
- enable  input  1  receive enable; low clears frame state synchronously
- bitStrobe  input  1  one-cycle pulse at each bit sample point
- rxBit  input  1  sampled line value, valid when bitStrobe=1
- charRec  output  1  one-cycle pulse: full frame received
- dataOut  output  DATA_BITS  received character, LSB = first data bit
- frameErr  output  1  a stop bit sampled 0 in the last frame
- busy  output  1  frame in progress (bitIndex != 0)
- bitIndex  output  CW  current bit position; CW = $clog2(FRAME_LEN+1)

## Operation
- FRAME_LEN = 1 + DATA_BITS + P + STOP_BITS; P = 1 with BIC_PARITY_EN, else 0.
- Priority per cycle: reset_n=0 > enable=0 > bitStrobe.
- States: IDLE (bitIndex=0), DATA, PARITY (macro only), STOP; state derived from bitIndex.
- IDLE + strobe: rxBit=0 -> valid start, bitIndex=1. rxBit=1 -> false start, stay IDLE, no pulse.
- DATA (bitIndex 1..DATA_BITS) + strobe: rxBit shifted into shift register from MSB end (LSB-first line order), bitIndex+1.
- STOP + strobe: rxBit=0 sets internal stop-error flag; bitIndex+1.
- Strobe at bitIndex = FRAME_LEN-1: next cycle bitIndex=0, charRec=1, dataOut and frameErr (and parityErr) loaded from shift register/flags.
- dataOut, frameErr, parityErr hold until the next charRec; not cleared by enable=0.
- enable=0: bitIndex=0, shift register and stop-error flag cleared, charRec=0; aborted frame produces no pulse.
- No strobe: all state holds. Strobes may arrive back-to-back (every cycle).
- Arithmetic: bitIndex never exceeds FRAME_LEN-1; wraps to 0 only via completion, false-start, enable or reset.

## Timing
- Reset values: charRec=0, dataOut=0, frameErr=0, parityErr=0, busy=0, bitIndex=0.
- Latency: charRec asserts exactly 1 cycle after the final stop-bit strobe; width 1 cycle.
- busy is combinational from bitIndex (no extra latency).
- Start strobe of next frame accepted in the same cycle charRec is high.
- reset_n low mid-frame: next cycle all outputs at reset values, partial frame discarded.
- Simultaneous enable=0 and last-bit strobe: enable wins; no charRec, outputs unchanged.

## Configuration
- BIC_PARITY_EN defined: one parity bit after data; PARITY_ODD parameter (default 0 = even) and output parityErr (1 bit) added; parityErr = XOR of data bits and parity bit != PARITY_ODD, loaded with charRec. FRAME_LEN includes parity bit.
- Undefined: no parity slot, no parityErr port, PARITY_ODD absent.

## Test plan
- Default params, macro off: reset, enable=1, frame 0,(0x A5 LSB-first),1 on 10 strobes -> charRec pulse 1 cycle after 10th strobe, dataOut=0xA5, frameErr=0, bitIndex=0.
- Stop bit sampled 0 on frame carrying 0x3C -> charRec=1, dataOut=0x3C, frameErr=1; next good frame clears frameErr.
- Start strobe with rxBit=1 -> bitIndex stays 0, busy=0, no charRec.
- enable dropped at bitIndex=5 -> bitIndex=0 next cycle, no charRec, dataOut keeps previous value; reset_n=0 mid-frame -> all outputs 0.
- DATA_BITS=7, STOP_BITS=2, back-to-back strobes every cycle, two frames 0x55 then 0x2A -> 10-strobe frames, two charRec pulses, dataOut correct each.
- BIC_PARITY_EN, even parity, data 0x07 with parity bit 0 -> charRec=1, parityErr=1; parity bit 1 -> parityErr=0.
